// File: rtl/srl_pipe_if.sv
// Operand/result handshake bundle for srl_pipe.
// master = producer/consumer side, slave = the shifter itself.
interface srl_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  modport master (
    output in_valid, a, amt, arith, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, amt, arith, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/srl_pipe.sv
// Five-stage pipelined 32-bit right barrel shifter with valid/ready on both sides.
// Define SRL_PIPE_ARITH_EN to honor the arith input (sign fill); otherwise logical only.
module srl_pipe (
  input logic        clock,
  input logic        resetn,
  srl_pipe_if.slave  bus
);

  // Right shift with an arbitrary fill bit: inverting around a logical shift sign-fills.
  function automatic logic [31:0] shr(input logic [31:0] x, input logic f, input logic [4:0] n);
    return f ? ~((~x) >> n) : (x >> n);
  endfunction

  logic        adv;
  logic        fill_in;
  logic [5:1]  v;
  logic [31:0] d [1:5];
  logic [3:0]  r1;
  logic [2:0]  r2;
  logic [1:0]  r3;
  logic        r4;
  logic [4:1]  f;

  // Whole pipe moves in lockstep; only a stalled valid result can hold it.
  assign adv          = !v[5] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v[5];
  assign bus.out      = v[5] ? d[5] : 32'h0;

`ifdef SRL_PIPE_ARITH_EN
  assign fill_in = bus.arith & bus.a[31];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      f <= '0;
    end else if (adv) begin
      f <= {f[3:1], fill_in};
    end
  end
`else
  assign fill_in = 1'b0;
  assign f       = '0;
`endif

  // Stage k applies shift 2^(k-1); remaining amount bits travel alongside the data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v    <= '0;
      d[1] <= '0;
      d[2] <= '0;
      d[3] <= '0;
      d[4] <= '0;
      d[5] <= '0;
      r1   <= '0;
      r2   <= '0;
      r3   <= '0;
      r4   <= 1'b0;
    end else if (adv) begin
      v    <= {v[4:1], bus.in_valid};
      d[1] <= shr(bus.a, fill_in, bus.amt[0] ? 5'd1  : 5'd0);
      d[2] <= shr(d[1],  f[1],    r1[0]      ? 5'd2  : 5'd0);
      d[3] <= shr(d[2],  f[2],    r2[0]      ? 5'd4  : 5'd0);
      d[4] <= shr(d[3],  f[3],    r3[0]      ? 5'd8  : 5'd0);
      d[5] <= shr(d[4],  f[4],    r4         ? 5'd16 : 5'd0);
      r1   <= bus.amt[4:1];
      r2   <= r1[3:1];
      r3   <= r2[2:1];
      r4   <= r3[1];
    end
  end

endmodule

// File: tb/tb_srl_pipe.sv
// Self-checking bench for srl_pipe: directed cases plus randomized traffic against a
// queue-based reference model of shift results and pipeline timing.
module tb_srl_pipe;

`ifdef SRL_PIPE_ARITH_EN
  localparam bit ARITH_EN = 1'b1;
`else
  localparam bit ARITH_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] val;
    int          stamp;
  } entry_t;

  logic clock;
  logic resetn;
  srl_pipe_if bus ();

  srl_pipe dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int     checks   = 0;
  int     failures = 0;
  int     popped   = 0;
  int     advCount = 0;
  entry_t q[$];
  logic   expValid;
  logic   expAdv;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] refShift(input logic [31:0] a, input logic [4:0] amt, input logic arith);
    logic signed [31:0] s;
    logic [31:0]        r;
    s = a;
    if (ARITH_EN && arith) r = s >>> amt;
    else                   r = a >> amt;
    return r;
  endfunction

  // Reference: each accepted operand becomes valid after four further pipe advances
  // following its capture edge; a valid head stalls the pipe until out_ready.
  always @(negedge clock) begin
    if (!resetn) begin
      checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("rst_out",       bus.out,                32'd0);
      checkOutput("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
      q.delete();
    end else begin
      expValid = (q.size() > 0) && (advCount - q[0].stamp >= 4);
      expAdv   = !expValid || bus.out_ready;
      checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, expValid});
      checkOutput("in_ready",  {31'b0, bus.in_ready},  {31'b0, expAdv});
      checkOutput("out",       bus.out,                expValid ? q[0].val : 32'h0);
      if (expAdv) begin
        advCount++;
        if (expValid) begin
          void'(q.pop_front());
          popped++;
        end
        if (bus.in_valid)
          q.push_back('{refShift(bus.a, bus.amt, bus.arith), advCount});
      end
    end
  end

  // Present one operand and return just after the edge that accepts it.
  task automatic applyStimulus(input logic [31:0] a, input logic [4:0] amt, input logic arith);
    bit done;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.amt      = amt;
    bus.arith    = arith;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (bus.in_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic runDirected(input string tag, input logic [31:0] a, input logic [4:0] amt,
                             input logic arith, input logic [31:0] expected);
    bit seen;
    applyStimulus(a, amt, arith);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        seen = 1'b1;
        checkOutput(tag, bus.out, expected);
      end
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int startPop;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.amt       = '0;
    bus.arith     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset_out",       bus.out,                32'd0);
    checkOutput("reset_in_ready",  {31'b0, bus.in_ready},  32'd1);
    @(posedge clock);
    #1;

    runDirected("lsr_1",  32'h80000001, 5'd1,  1'b0, 32'h40000000);
    runDirected("lsr_31", 32'h80000001, 5'd31, 1'b0, 32'h00000001);
    runDirected("lsr_0",  32'h80000001, 5'd0,  1'b0, 32'h80000001);
    runDirected("asr_4",  32'h80000000, 5'd4,  1'b1, ARITH_EN ? 32'hF8000000 : 32'h08000000);
    runDirected("asr_31", 32'hF0000000, 5'd31, 1'b1, ARITH_EN ? 32'hFFFFFFFF : 32'h00000001);

    // Back-to-back stream of eight operands.
    startPop = popped;
    for (int i = 0; i < 8; i++)
      applyStimulus($urandom, 5'($urandom_range(0, 31)), 1'($urandom));
    idleCycles(10);
    checkOutput("stream_count", 32'(popped - startPop), 32'd8);

    // Backpressure with the pipe full.
    for (int i = 0; i < 6; i++)
      applyStimulus($urandom | 32'h80000000, 5'($urandom_range(0, 31)), 1'b1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    idleCycles(0);
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    checkOutput("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    idleCycles(12);

    // Reset with operands in flight.
    for (int i = 0; i < 3; i++)
      applyStimulus($urandom, 5'($urandom_range(0, 31)), 1'($urandom));
    idleCycles(2);
    checkOutput("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("mid_rst_out",   bus.out,                32'd0);
    idleCycles(2);
    resetn = 1'b1;
    idleCycles(8);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = $urandom;
      bus.amt       = 5'($urandom_range(0, 31));
      bus.arith     = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    idleCycles(12);
    checkOutput("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
